// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg -- shared CPU constants for the fetch stage.
//   PC_RESET        : first fetch address after reset
//   NPC_SEQ..NPC_JR : encodings of the ID-stage next-PC select (npc_sel)
//   ifid_t          : contents of the IF/ID pipeline register
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    localparam logic [1:0] NPC_SEQ = 2'd0;  // F_PC + 4
    localparam logic [1:0] NPC_BR  = 2'd1;  // taken branch
    localparam logic [1:0] NPC_J   = 2'd2;  // j / jal
    localparam logic [1:0] NPC_JR  = 2'd3;  // jr / jalr

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_npc.sv
// ---------------------------------------------------------------------------
// npc -- combinational next-PC selection for the fetch stage.
// Ports:
//   f_pc           in  32  current fetch PC
//   npc_sel        in   2  select (NPC_SEQ / NPC_BR / NPC_J / NPC_JR)
//   id_pc          in  32  PC of the instruction in ID
//   id_imm16       in  16  branch offset (words, signed)
//   id_instr_index in  26  jump target field
//   id_rs_data     in  32  forwarded rs for jr/jalr
//   next_pc        out 32  PC to load into F_PC on the next edge
// All arithmetic is 32-bit modulo.
// ---------------------------------------------------------------------------
module npc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] f_pc,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_instr_index,
    input  logic [31:0] id_rs_data,
    output logic [31:0] next_pc
);

    logic signed [31:0] br_off;

    always_comb begin
        // Word offset sign-extended and scaled to bytes.
        br_off  = {{14{id_imm16[15]}}, id_imm16, 2'b00};
        next_pc = f_pc + 32'd4;
        case (npc_sel)
            NPC_BR:  next_pc = id_pc + 32'd4 + $unsigned(br_off);
            NPC_J:   next_pc = {id_pc[31:28], id_instr_index, 2'b00};
            // Register target is taken as-is; misalignment is not masked here.
            NPC_JR:  next_pc = id_rs_data;
            default: next_pc = f_pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch: F_PC register and IF/ID register.
// Configuration macro: DELAY_SLOT_EN
//   defined   : the instruction fetched alongside a redirect is kept
//               (branch delay slot) and latched with d_valid=1
//   undefined : a redirect loads a bubble (all zero, d_valid=0) into IF/ID
// Ports:
//   clk            in  1   system clock, rising edge
//   reset          in  1   synchronous, active-high
//   stall          in  1   freeze F_PC and IF/ID (wins over redirect)
//   npc_sel        in  2   ID redirect select
//   id_pc          in  32  PC of the ID instruction
//   id_imm16       in  16  branch offset field
//   id_instr_index in  26  jump target field
//   id_rs_data     in  32  forwarded rs value
//   im_addr        out 32  instruction-memory address (= F_PC)
//   im_rdata       in  32  instruction-memory data for im_addr
//   d_instr        out 32  IF/ID instruction
//   d_pc, d_pc8    out 32  IF/ID PC and PC+8
//   d_valid        out 1   IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = fetch_stage_pkg::PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_instr_index,
    input  logic [31:0] id_rs_data,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid
);

    logic [31:0] f_pc;
    logic [31:0] next_pc;
    ifid_t       ifid_p1;
    logic        redirect_flush;

    npc u_npc (
        .f_pc           (f_pc),
        .npc_sel        (npc_sel),
        .id_pc          (id_pc),
        .id_imm16       (id_imm16),
        .id_instr_index (id_instr_index),
        .id_rs_data     (id_rs_data),
        .next_pc        (next_pc)
    );

`ifdef DELAY_SLOT_EN
    assign redirect_flush = 1'b0;
`else
    assign redirect_flush = (npc_sel != NPC_SEQ);
`endif

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc    <= PC_RESET;
            ifid_p1 <= '0;
        end else if (!stall) begin
            f_pc <= next_pc;
            if (redirect_flush) begin
                ifid_p1 <= '0;
            end else begin
                ifid_p1 <= '{instr: im_rdata, pc: f_pc, pc8: f_pc + 32'd8, valid: 1'b1};
            end
        end
    end

    assign im_addr = f_pc;
    assign d_instr = ifid_p1.instr;
    assign d_pc    = ifid_p1.pc;
    assign d_pc8   = ifid_p1.pc8;
    assign d_valid = ifid_p1.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- directed scenarios plus randomized traffic for
// fetch_stage, compared against a behavioural fetch model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic [31:0] id_pc;
    logic [15:0] id_imm16;
    logic [25:0] id_instr_index;
    logic [31:0] id_rs_data;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [31:0] m_fpc;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_pc8;
    logic        m_valid;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .npc_sel        (npc_sel),
        .id_pc          (id_pc),
        .id_imm16       (id_imm16),
        .id_instr_index (id_instr_index),
        .id_rs_data     (id_rs_data),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .d_instr        (d_instr),
        .d_pc           (d_pc),
        .d_pc8          (d_pc8),
        .d_valid        (d_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: every address holds a distinct pseudo-random word.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign im_rdata = imem(im_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    // One clock edge of the reference fetch stage.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        redirect;
        int          off;
        if (reset) begin
            m_fpc   = 32'h0000_3000;
            m_instr = 0;
            m_pc    = 0;
            m_pc8   = 0;
            m_valid = 0;
        end else if (!stall) begin
            off = int'($signed(id_imm16));
            case (npc_sel)
                2'd1:    tgt = id_pc + 32'd4 + 32'(off * 4);
                2'd2:    tgt = (id_pc & 32'hF000_0000) | (32'(id_instr_index) * 32'd4);
                2'd3:    tgt = id_rs_data;
                default: tgt = m_fpc + 32'd4;
            endcase
`ifdef DELAY_SLOT_EN
            redirect = 1'b0;
`else
            redirect = (npc_sel != 2'd0);
`endif
            if (redirect) begin
                m_instr = 0;
                m_pc    = 0;
                m_pc8   = 0;
                m_valid = 0;
            end else begin
                m_instr = imem(m_fpc);
                m_pc    = m_fpc;
                m_pc8   = m_fpc + 32'd8;
                m_valid = 1;
            end
            m_fpc = tgt;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".im_addr"}, im_addr, m_fpc);
        chk({tag, ".d_instr"}, d_instr, m_instr);
        chk({tag, ".d_pc"},    d_pc,    m_pc);
        chk({tag, ".d_pc8"},   d_pc8,   m_pc8);
        chk({tag, ".d_valid"}, {31'd0, d_valid}, {31'd0, m_valid});
    endtask

    initial begin
        logic [31:0] hold_fpc;
        logic [31:0] hold_instr;
        logic [31:0] hold_pc;

        reset = 1; stall = 0; npc_sel = 0;
        id_pc = 0; id_imm16 = 0; id_instr_index = 0; id_rs_data = 0;
        m_fpc = 0; m_instr = 0; m_pc = 0; m_pc8 = 0; m_valid = 0;

        // Reset for two cycles
        cycle(); cycle();
        chk("rst.im_addr", im_addr, 32'h3000);
        chk("rst.d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst.d_instr", d_instr, 32'd0);
        chk("rst.d_pc", d_pc, 32'd0);
        reset = 0;
        cycle();
        chk("rel.d_pc", d_pc, 32'h3000);
        chk("rel.d_valid", {31'd0, d_valid}, 32'd1);
        chk("rel.d_instr", d_instr, imem(32'h3000));

        // Sequential fetch
        cycle(); cycle();
        chk("seq.im_addr", im_addr, 32'h300C);
        chk("seq.d_pc", d_pc, 32'h3008);
        chk("seq.d_pc8", d_pc8, 32'h3010);

        // Backward branch by one word
        id_pc = 32'h3004; id_imm16 = 16'hFFFF; npc_sel = 1;
        cycle();
        chk("br.im_addr", im_addr, 32'h3004);
`ifdef DELAY_SLOT_EN
        chk("br.d_valid", {31'd0, d_valid}, 32'd1);
        chk("br.d_pc", d_pc, 32'h300C);
`else
        chk("br.d_valid", {31'd0, d_valid}, 32'd0);
        chk("br.d_pc", d_pc, 32'd0);
        chk("br.d_instr", d_instr, 32'd0);
`endif
        check_all("br");
        npc_sel = 0;
        cycle();
        check_all("br_after");

        // Jump and jump-register
        id_pc = 32'h3008; id_instr_index = 26'h0000C10; npc_sel = 2;
        cycle();
        chk("j.im_addr", im_addr, 32'h3040);
        id_rs_data = 32'h3100; npc_sel = 3;
        cycle();
        chk("jr.im_addr", im_addr, 32'h3100);
        check_all("jr");
        npc_sel = 0;
        cycle();

        // Stall beats redirect
        hold_fpc = m_fpc; hold_instr = m_instr; hold_pc = m_pc;
        stall = 1; npc_sel = 1; id_pc = 32'h3200; id_imm16 = 16'h0010;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall.im_addr", im_addr, hold_fpc);
            chk("stall.d_instr", d_instr, hold_instr);
            chk("stall.d_pc", d_pc, hold_pc);
        end
        stall = 0;
        cycle();
        chk("unstall.im_addr", im_addr, 32'h3244);
        check_all("unstall");
        npc_sel = 0;
        cycle();

        // Reset coinciding with a jump
        reset = 1; npc_sel = 2; id_pc = 32'h3008; id_instr_index = 26'h0000C10;
        cycle();
        chk("rstj.im_addr", im_addr, 32'h3000);
        chk("rstj.d_valid", {31'd0, d_valid}, 32'd0);
        reset = 0; npc_sel = 0;
        cycle();
        chk("rstj.d_pc", d_pc, 32'h3000);
        chk("rstj.d_instr", d_instr, imem(32'h3000));
        chk("rstj.d_valid", {31'd0, d_valid}, 32'd1);

        // Address wrap and unaligned jr target
        id_rs_data = 32'hFFFF_FFFC; npc_sel = 3;
        cycle();
        chk("wrap.im_addr0", im_addr, 32'hFFFF_FFFC);
        npc_sel = 0;
        cycle();
        chk("wrap.im_addr1", im_addr, 32'h0);
        chk("wrap.d_pc", d_pc, 32'hFFFF_FFFC);
        chk("wrap.d_pc8", d_pc8, 32'h4);
        id_rs_data = 32'h0000_3101; npc_sel = 3;
        cycle();
        chk("jr_unaligned.im_addr", im_addr, 32'h0000_3101);
        npc_sel = 0;
        cycle();
        check_all("jr_unaligned");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            npc_sel        = 2'($urandom_range(0, 3));
            id_pc          = $urandom & 32'hFFFF_FFFC;
            id_imm16       = 16'($urandom);
            id_instr_index = 26'($urandom);
            id_rs_data     = $urandom;
            cycle();
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
